axi_bus_reg_slice: RTL and testbench
====================================

Name: axi_bus_reg_slice

Overview:
- Full AXI4 register slice that sits on one AXI_BUS segment (32-bit addr, 64-bit data, 6-bit ID, 1-bit user), e.g. between the core master port and the CDC/DDR path.
- Breaks every combinational path (valid, ready and payload) on all five channels.
- Each channel is an independent two-entry skid buffer:
  - full throughput of one beat per cycle;
  - registered ready toward the upstream side.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 64, data width; must be a multiple of 8.
- ID_WIDTH, 6, transaction ID width.
- USER_WIDTH, 1, user sideband width on every channel.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rstn  in  1  reset is asynchronous and active-low.
- s_aw_valid/s_aw_ready/s_aw  in/out/in  1/1/AW_W  write-address channel from upstream master.
- s_w_valid/s_w_ready/s_w  in/out/in  1/1/W_W  write-data channel from upstream.
- s_b_valid/s_b_ready/s_b  out/in/out  1/1/B_W  write-response channel to upstream.
- s_ar_valid/s_ar_ready/s_ar  in/out/in  1/1/AR_W  read-address channel from upstream.
- s_r_valid/s_r_ready/s_r  out/in/out  1/1/R_W  read-data channel to upstream.
- m_aw_*, m_w_*, m_b_*, m_ar_*, m_r_*  mirrored directions  same widths  downstream side.
- Payload packing, MSB to LSB:
  - AW = {id, addr, len8, size3, burst2, lock1, cache4, prot3, region4, qos4, atop6, user}
  - AR = AW without atop
  - W = {data, strb DATA_WIDTH/8, last, user}
  - B = {id, resp2, user}
  - R = {id, data, resp2, last, user}

Behaviour:
- Forward channels (AW, W, AR) flow s to m; backward channels (B, R) flow m to s. All five use one identical skid-buffer cell.
- Cell state:
  - main register: valid bit + payload;
  - skid register: valid bit + payload.
- Cell ready:
  - upstream ready = NOT skid_valid, driven straight from a flop.
  - output valid = main_valid; output payload = main payload.
- Update on each clock, where in_hs = in_valid&in_ready and out_hs = out_valid&out_ready:
  - main empty, or out_hs: main loads skid if skid_valid, else loads input if in_hs, else becomes empty.
  - When main loads from skid and in_hs occurs in the same cycle: the input goes into skid.
  - main full, no out_hs, in_hs: input goes to skid, so upstream ready drops next cycle.
- Latency and throughput:
  - Exactly 1 cycle from input handshake to output valid when the slice is empty.
  - Sustained 1 beat/cycle with out_ready held high.
- Ordering and stability:
  - Strict FIFO order per channel; no beat is dropped or duplicated.
  - While out_valid&!out_ready, the output payload and valid are held stable (AXI rule).
- Full condition: main and skid both valid means upstream ready = 0, with capacity 2. Simultaneous in_hs and out_hs in the full state is impossible because ready is 0.
- Channel independence: channels do not interact. There is no AW/W coupling and no ID reordering; ID, len and last pass through unmodified.
- Reset:
  - rstn low asynchronously clears all valid bits and zeroes all payload registers.
  - Outputs during/after reset: all m_*_valid and s_b/s_r_valid = 0; all upstream readies = 1 (skid empty).
  - Reset mid-burst discards in-flight beats; no recovery logic.

Optional Feature:
- AXI_SLICE_ATOP_EN
  - Defined: the 6-bit atop field is registered and forwarded like any other AW bit.
  - Undefined: atop is not stored and m_aw atop bits are tied to 0, whatever s_aw carries. AW storage shrinks by 6 bits per entry.

Decomposition:
- Package axi_bus_slice_pkg holds:
  - width constants AW_W, W_W, B_W, AR_W, R_W, derived from the parameters;
  - field offset constants for the packing above;
  - response encodings OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3.
- Sub-module axi_skid_cell (parameter WIDTH): one instance per channel, five in total.

Test Plan:
- Single AW: s_aw addr=0x8000_0010, id=5, len=3, m_aw_ready=1 → m_aw_valid high exactly 1 cycle after handshake with identical payload; s_aw_ready stays 1.
- Backpressure: hold m_w_ready=0 and push 3 W beats → 2 accepted, s_w_ready=0 on the cycle after the second beat. Release → beats emerge in order with data 0x1111…, 0x2222…, and wlast intact.
- Streaming: 16-beat R burst with m_r_valid and s_r_ready both held 1 → 16 consecutive s_r beats, no bubbles, rlast only on beat 16, rid constant.
- Random valid/ready toggling on all five channels for 10k cycles → scoreboard shows no loss, no duplication, no reordering, and payload stable whenever valid&!ready.
- Reset mid-operation: rstn=0 with both entries full → same-cycle (async) m_*_valid=0; after release all upstream readies=1.
- ATOP: s_aw atop=6'h21 → m_aw atop=6'h21 with AXI_SLICE_ATOP_EN defined, 6'h00 without.

Source files
------------

// File: rtl/axi_bus_slice_pkg.sv
// -----------------------------------------------------------------------------
// axi_bus_slice_pkg
//
// Purpose: shared definitions for the AXI_BUS register slice.
//   - width helpers that derive each channel's packed payload width from the
//     bus parameters, plus the widths for the default bus (32/64/6/1);
//   - field offsets (LSB positions) for the default-bus payload packing;
//   - AXI response encodings.
//
// Payload packing, MSB to LSB:
//   AW = {id, addr, len8, size3, burst2, lock1, cache4, prot3, region4, qos4,
//         atop6, user}
//   AR = AW without atop
//   W  = {data, strb, last, user}
//   B  = {id, resp2, user}
//   R  = {id, data, resp2, last, user}
// -----------------------------------------------------------------------------
package axi_bus_slice_pkg;

    // Default AXI_BUS segment geometry
    localparam int ADDR_WIDTH_DEF = 32;
    localparam int DATA_WIDTH_DEF = 64;
    localparam int ID_WIDTH_DEF   = 6;
    localparam int USER_WIDTH_DEF = 1;

    // len8 + size3 + burst2 + lock1 + cache4 + prot3 + region4 + qos4
    localparam int AX_FIXED_BITS = 29;
    localparam int ATOP_BITS     = 6;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } axi_resp_e;

    function automatic int ar_width(input int id_w, input int addr_w, input int user_w);
        return id_w + addr_w + AX_FIXED_BITS + user_w;
    endfunction

    function automatic int aw_width(input int id_w, input int addr_w, input int user_w);
        return ar_width(id_w, addr_w, user_w) + ATOP_BITS;
    endfunction

    function automatic int w_width(input int data_w, input int user_w);
        return data_w + data_w / 8 + 1 + user_w;
    endfunction

    function automatic int b_width(input int id_w, input int user_w);
        return id_w + 2 + user_w;
    endfunction

    function automatic int r_width(input int id_w, input int data_w, input int user_w);
        return id_w + data_w + 2 + 1 + user_w;
    endfunction

    // Channel widths for the default bus
    localparam int AW_W = aw_width(ID_WIDTH_DEF, ADDR_WIDTH_DEF, USER_WIDTH_DEF);
    localparam int AR_W = ar_width(ID_WIDTH_DEF, ADDR_WIDTH_DEF, USER_WIDTH_DEF);
    localparam int W_W  = w_width(DATA_WIDTH_DEF, USER_WIDTH_DEF);
    localparam int B_W  = b_width(ID_WIDTH_DEF, USER_WIDTH_DEF);
    localparam int R_W  = r_width(ID_WIDTH_DEF, DATA_WIDTH_DEF, USER_WIDTH_DEF);

    // AW field offsets (default bus)
    localparam int AW_USER_LSB   = 0;
    localparam int AW_ATOP_LSB   = AW_USER_LSB + USER_WIDTH_DEF;
    localparam int AW_QOS_LSB    = AW_ATOP_LSB + ATOP_BITS;
    localparam int AW_REGION_LSB = AW_QOS_LSB + 4;
    localparam int AW_PROT_LSB   = AW_REGION_LSB + 4;
    localparam int AW_CACHE_LSB  = AW_PROT_LSB + 3;
    localparam int AW_LOCK_LSB   = AW_CACHE_LSB + 4;
    localparam int AW_BURST_LSB  = AW_LOCK_LSB + 1;
    localparam int AW_SIZE_LSB   = AW_BURST_LSB + 2;
    localparam int AW_LEN_LSB    = AW_SIZE_LSB + 3;
    localparam int AW_ADDR_LSB   = AW_LEN_LSB + 8;
    localparam int AW_ID_LSB     = AW_ADDR_LSB + ADDR_WIDTH_DEF;

    // AR field offsets (same as AW, shifted down by the missing atop field)
    localparam int AR_USER_LSB   = 0;
    localparam int AR_QOS_LSB    = AR_USER_LSB + USER_WIDTH_DEF;
    localparam int AR_LEN_LSB    = AW_LEN_LSB - ATOP_BITS;
    localparam int AR_ADDR_LSB   = AW_ADDR_LSB - ATOP_BITS;
    localparam int AR_ID_LSB     = AW_ID_LSB - ATOP_BITS;

    // W field offsets
    localparam int W_USER_LSB    = 0;
    localparam int W_LAST_LSB    = W_USER_LSB + USER_WIDTH_DEF;
    localparam int W_STRB_LSB    = W_LAST_LSB + 1;
    localparam int W_DATA_LSB    = W_STRB_LSB + DATA_WIDTH_DEF / 8;

    // B field offsets
    localparam int B_USER_LSB    = 0;
    localparam int B_RESP_LSB    = B_USER_LSB + USER_WIDTH_DEF;
    localparam int B_ID_LSB      = B_RESP_LSB + 2;

    // R field offsets
    localparam int R_USER_LSB    = 0;
    localparam int R_LAST_LSB    = R_USER_LSB + USER_WIDTH_DEF;
    localparam int R_RESP_LSB    = R_LAST_LSB + 1;
    localparam int R_DATA_LSB    = R_RESP_LSB + 2;
    localparam int R_ID_LSB      = R_DATA_LSB + DATA_WIDTH_DEF;

endpackage

// File: rtl/axi_skid_cell.sv
// -----------------------------------------------------------------------------
// axi_skid_cell
//
// Purpose: two-entry skid buffer for one valid/ready channel. Every output
// (in_ready, out_valid, out_data) comes directly from a flop, so no
// combinational path crosses the cell. Sustains one beat per cycle.
//
// Parameters:
//   WIDTH      payload width
// Ports:
//   clk        clock, rising edge
//   rstn       asynchronous active-low reset (clears valids, zeroes payloads)
//   in_valid   upstream valid
//   in_ready   upstream ready (registered; low only while the skid entry is used)
//   in_data    upstream payload
//   out_valid  downstream valid (main entry valid)
//   out_ready  downstream ready
//   out_data   downstream payload (main entry payload)
// -----------------------------------------------------------------------------
module axi_skid_cell #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             main_valid_reg, main_valid_next;
    logic [WIDTH-1:0] main_data_reg,  main_data_next;
    logic             skid_valid_reg, skid_valid_next;
    logic [WIDTH-1:0] skid_data_reg,  skid_data_next;
    logic             ready_reg;

    logic in_hs;
    logic out_hs;

    assign in_hs     = in_valid & ready_reg;
    assign out_hs    = main_valid_reg & out_ready;
    assign in_ready  = ready_reg;
    assign out_valid = main_valid_reg;
    assign out_data  = main_data_reg;

    always_comb begin
        main_valid_next = main_valid_reg;
        main_data_next  = main_data_reg;
        skid_valid_next = skid_valid_reg;
        skid_data_next  = skid_data_reg;

        if (!main_valid_reg || out_hs) begin
            // Main entry is free this cycle: the oldest beat moves in.
            if (skid_valid_reg) begin
                main_valid_next = 1'b1;
                main_data_next  = skid_data_reg;
                skid_valid_next = in_hs;
                if (in_hs) begin
                    skid_data_next = in_data;
                end
            end else begin
                main_valid_next = in_hs;
                if (in_hs) begin
                    main_data_next = in_data;
                end
            end
        end else if (in_hs) begin
            // Main is stalled: park the new beat in the skid entry.
            skid_valid_next = 1'b1;
            skid_data_next  = in_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            main_valid_reg <= 1'b0;
            main_data_reg  <= '0;
            skid_valid_reg <= 1'b0;
            skid_data_reg  <= '0;
            ready_reg      <= 1'b1;
        end else begin
            main_valid_reg <= main_valid_next;
            main_data_reg  <= main_data_next;
            skid_valid_reg <= skid_valid_next;
            skid_data_reg  <= skid_data_next;
            // Ready is a flop of its own so upstream sees no logic after it.
            ready_reg      <= ~skid_valid_next;
        end
    end

endmodule

// File: rtl/axi_bus_reg_slice.sv
// -----------------------------------------------------------------------------
// axi_bus_reg_slice
//
// Purpose: full AXI4 register slice for one AXI_BUS segment. Each of the five
// channels runs through its own axi_skid_cell, so valid, ready and payload
// are all registered in both directions. Channels are fully independent.
//
// Configuration macro: AXI_SLICE_ATOP_EN
//   defined   - the 6-bit atop field is stored and forwarded on m_aw.
//   undefined - atop is not stored; m_aw atop bits are driven to zero.
//
// Ports (packing defined in axi_bus_slice_pkg):
//   clk, rstn                      clock / async active-low reset
//   s_aw_valid/s_aw_ready/s_aw     write address from upstream master
//   s_w_valid/s_w_ready/s_w        write data from upstream master
//   s_b_valid/s_b_ready/s_b        write response to upstream master
//   s_ar_valid/s_ar_ready/s_ar     read address from upstream master
//   s_r_valid/s_r_ready/s_r        read data to upstream master
//   m_aw_*, m_w_*, m_b_*, m_ar_*, m_r_*  same channels, downstream side
// -----------------------------------------------------------------------------
module axi_bus_reg_slice
    import axi_bus_slice_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 6,
    parameter int USER_WIDTH = 1,
    localparam int AW_BITS   = aw_width(ID_WIDTH, ADDR_WIDTH, USER_WIDTH),
    localparam int AR_BITS   = ar_width(ID_WIDTH, ADDR_WIDTH, USER_WIDTH),
    localparam int W_BITS    = w_width(DATA_WIDTH, USER_WIDTH),
    localparam int B_BITS    = b_width(ID_WIDTH, USER_WIDTH),
    localparam int R_BITS    = r_width(ID_WIDTH, DATA_WIDTH, USER_WIDTH)
) (
    input  logic               clk,
    input  logic               rstn,

    input  logic               s_aw_valid,
    output logic               s_aw_ready,
    input  logic [AW_BITS-1:0] s_aw,
    input  logic               s_w_valid,
    output logic               s_w_ready,
    input  logic [W_BITS-1:0]  s_w,
    output logic               s_b_valid,
    input  logic               s_b_ready,
    output logic [B_BITS-1:0]  s_b,
    input  logic               s_ar_valid,
    output logic               s_ar_ready,
    input  logic [AR_BITS-1:0] s_ar,
    output logic               s_r_valid,
    input  logic               s_r_ready,
    output logic [R_BITS-1:0]  s_r,

    output logic               m_aw_valid,
    input  logic               m_aw_ready,
    output logic [AW_BITS-1:0] m_aw,
    output logic               m_w_valid,
    input  logic               m_w_ready,
    output logic [W_BITS-1:0]  m_w,
    input  logic               m_b_valid,
    output logic               m_b_ready,
    input  logic [B_BITS-1:0]  m_b,
    output logic               m_ar_valid,
    input  logic               m_ar_ready,
    output logic [AR_BITS-1:0] m_ar,
    input  logic               m_r_valid,
    output logic               m_r_ready,
    input  logic [R_BITS-1:0]  m_r
);

    // atop sits directly above the user field in the AW packing.
    localparam int ATOP_LSB = USER_WIDTH;

`ifdef AXI_SLICE_ATOP_EN
    localparam int AW_STORE = AW_BITS;

    logic [AW_STORE-1:0] aw_in_packed;
    logic [AW_STORE-1:0] aw_out_packed;

    assign aw_in_packed = s_aw;
    assign m_aw         = aw_out_packed;
`else
    localparam int AW_STORE = AW_BITS - ATOP_BITS;

    logic [AW_STORE-1:0] aw_in_packed;
    logic [AW_STORE-1:0] aw_out_packed;
    logic                unused_atop;

    // Squeeze atop out before storage and re-insert zeros on the way out.
    assign aw_in_packed = {s_aw[AW_BITS-1:ATOP_LSB+ATOP_BITS], s_aw[USER_WIDTH-1:0]};
    assign m_aw         = {aw_out_packed[AW_STORE-1:USER_WIDTH],
                           {ATOP_BITS{1'b0}},
                           aw_out_packed[USER_WIDTH-1:0]};
    assign unused_atop  = ^s_aw[ATOP_LSB +: ATOP_BITS];
`endif

    axi_skid_cell #(.WIDTH(AW_STORE)) u_aw_cell (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (s_aw_valid),
        .in_ready  (s_aw_ready),
        .in_data   (aw_in_packed),
        .out_valid (m_aw_valid),
        .out_ready (m_aw_ready),
        .out_data  (aw_out_packed)
    );

    axi_skid_cell #(.WIDTH(W_BITS)) u_w_cell (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (s_w_valid),
        .in_ready  (s_w_ready),
        .in_data   (s_w),
        .out_valid (m_w_valid),
        .out_ready (m_w_ready),
        .out_data  (m_w)
    );

    axi_skid_cell #(.WIDTH(AR_BITS)) u_ar_cell (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (s_ar_valid),
        .in_ready  (s_ar_ready),
        .in_data   (s_ar),
        .out_valid (m_ar_valid),
        .out_ready (m_ar_ready),
        .out_data  (m_ar)
    );

    // Response channels flow from the downstream port back to upstream.
    axi_skid_cell #(.WIDTH(B_BITS)) u_b_cell (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (m_b_valid),
        .in_ready  (m_b_ready),
        .in_data   (m_b),
        .out_valid (s_b_valid),
        .out_ready (s_b_ready),
        .out_data  (s_b)
    );

    axi_skid_cell #(.WIDTH(R_BITS)) u_r_cell (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (m_r_valid),
        .in_ready  (m_r_ready),
        .in_data   (m_r),
        .out_valid (s_r_valid),
        .out_ready (s_r_ready),
        .out_data  (s_r)
    );

endmodule

// File: tb/tb_axi_bus_reg_slice.sv
// -----------------------------------------------------------------------------
// tb_axi_bus_reg_slice
//
// Directed and random-traffic bench for axi_bus_reg_slice (default widths).
// Channels are handled uniformly through small arrays indexed
// 0=AW, 1=W, 2=AR, 3=B, 4=R, where "in" is the side that presents valid to
// the slice and "out" is the side the slice presents valid to.
// Honours AXI_SLICE_ATOP_EN for the expected m_aw atop field.
// -----------------------------------------------------------------------------
module tb_axi_bus_reg_slice;
    import axi_bus_slice_pkg::*;

    localparam int MAXW     = 74;
    localparam int NCH      = 5;
    localparam int RAND_CYC = 10000;
    localparam int DRAIN    = 40;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic s_aw_valid, s_aw_ready, s_w_valid, s_w_ready, s_b_valid, s_b_ready;
    logic s_ar_valid, s_ar_ready, s_r_valid, s_r_ready;
    logic m_aw_valid, m_aw_ready, m_w_valid, m_w_ready, m_b_valid, m_b_ready;
    logic m_ar_valid, m_ar_ready, m_r_valid, m_r_ready;
    logic [AW_W-1:0] s_aw, m_aw;
    logic [W_W-1:0]  s_w,  m_w;
    logic [B_W-1:0]  s_b,  m_b;
    logic [AR_W-1:0] s_ar, m_ar;
    logic [R_W-1:0]  s_r,  m_r;

    logic            in_v   [NCH];
    logic [MAXW-1:0] in_d   [NCH];
    logic            out_r  [NCH];
    logic            in_rdy [NCH];
    logic            out_v  [NCH];
    logic [MAXW-1:0] out_d  [NCH];

    int checks = 0;
    int passed = 0;

    axi_bus_reg_slice dut (
        .clk(clk), .rstn(rstn),
        .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw(s_aw),
        .s_w_valid(s_w_valid),   .s_w_ready(s_w_ready),   .s_w(s_w),
        .s_b_valid(s_b_valid),   .s_b_ready(s_b_ready),   .s_b(s_b),
        .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar(s_ar),
        .s_r_valid(s_r_valid),   .s_r_ready(s_r_ready),   .s_r(s_r),
        .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw(m_aw),
        .m_w_valid(m_w_valid),   .m_w_ready(m_w_ready),   .m_w(m_w),
        .m_b_valid(m_b_valid),   .m_b_ready(m_b_ready),   .m_b(m_b),
        .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar(m_ar),
        .m_r_valid(m_r_valid),   .m_r_ready(m_r_ready),   .m_r(m_r)
    );

    // Channel mapping: inputs to the DUT
    assign s_aw_valid = in_v[0];  assign s_aw = in_d[0][AW_W-1:0];  assign m_aw_ready = out_r[0];
    assign s_w_valid  = in_v[1];  assign s_w  = in_d[1][W_W-1:0];   assign m_w_ready  = out_r[1];
    assign s_ar_valid = in_v[2];  assign s_ar = in_d[2][AR_W-1:0];  assign m_ar_ready = out_r[2];
    assign m_b_valid  = in_v[3];  assign m_b  = in_d[3][B_W-1:0];   assign s_b_ready  = out_r[3];
    assign m_r_valid  = in_v[4];  assign m_r  = in_d[4][R_W-1:0];   assign s_r_ready  = out_r[4];
    // Channel mapping: outputs from the DUT
    assign in_rdy[0] = s_aw_ready; assign out_v[0] = m_aw_valid; assign out_d[0] = MAXW'(m_aw);
    assign in_rdy[1] = s_w_ready;  assign out_v[1] = m_w_valid;  assign out_d[1] = MAXW'(m_w);
    assign in_rdy[2] = s_ar_ready; assign out_v[2] = m_ar_valid; assign out_d[2] = MAXW'(m_ar);
    assign in_rdy[3] = m_b_ready;  assign out_v[3] = s_b_valid;  assign out_d[3] = MAXW'(s_b);
    assign in_rdy[4] = m_r_ready;  assign out_v[4] = s_r_valid;  assign out_d[4] = MAXW'(s_r);

    function automatic int chw(input int c);
        case (c)
            0:       return AW_W;
            1:       return W_W;
            2:       return AR_W;
            3:       return B_W;
            default: return R_W;
        endcase
    endfunction

    // Pseudo-random but reproducible payload for beat number seq of channel c.
    function automatic logic [MAXW-1:0] pay(input int c, input int unsigned seq);
        logic [MAXW-1:0] v;
        logic [MAXW-1:0] m;
        logic [9:0]      hi;
        hi = seq[9:0] ^ 10'(c * 97);
        v  = {hi, (64'(seq) * 64'h9E37_79B9_7F4A_7C15) ^ (64'(c + 1) << 56)};
        m  = (MAXW'(1) << chw(c)) - MAXW'(1);
        return v & m;
    endfunction

    // What the slice should present for an input payload on channel c.
    function automatic logic [MAXW-1:0] exp_out(input int c, input logic [MAXW-1:0] v);
        logic [MAXW-1:0] r;
        r = v;
`ifndef AXI_SLICE_ATOP_EN
        if (c == 0) r[AW_ATOP_LSB +: ATOP_BITS] = '0;
`endif
        return r;
    endfunction

    task automatic idle_all();
        for (int c = 0; c < NCH; c++) begin
            in_v[c]  = 1'b0;
            in_d[c]  = '0;
            out_r[c] = 1'b0;
        end
    endtask

    task automatic test_reset();
        idle_all();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        for (int c = 0; c < NCH; c++) begin
            checks++;
            if (out_v[c] !== 1'b0) $display("FAIL reset_out_valid ch%0d got=%b want=0", c, out_v[c]);
            else passed++;
            checks++;
            if (in_rdy[c] !== 1'b1) $display("FAIL reset_in_ready ch%0d got=%b want=1", c, in_rdy[c]);
            else passed++;
            checks++;
            if (out_d[c] !== '0) $display("FAIL reset_payload ch%0d got=%h want=0", c, out_d[c]);
            else passed++;
        end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_aw();
        logic [MAXW-1:0] aw;
        aw = MAXW'({6'd5, 32'h8000_0010, 8'd3, 3'd3, 2'd1, 1'b0, 4'h3, 3'h0, 4'h0, 4'h0, 6'h00, 1'b1});
        out_r[0] = 1'b1;
        in_v[0]  = 1'b1;
        in_d[0]  = aw;
        checks++;
        if (out_v[0] !== 1'b0) $display("FAIL aw_pre_valid got=%b want=0", out_v[0]);
        else passed++;
        checks++;
        if (in_rdy[0] !== 1'b1) $display("FAIL aw_pre_ready got=%b want=1", in_rdy[0]);
        else passed++;
        @(negedge clk);
        in_v[0] = 1'b0;
        checks++;
        if (out_v[0] !== 1'b1) $display("FAIL aw_latency_valid got=%b want=1", out_v[0]);
        else passed++;
        checks++;
        if (out_d[0] !== exp_out(0, aw)) $display("FAIL aw_payload got=%h want=%h", out_d[0], exp_out(0, aw));
        else passed++;
        checks++;
        if (in_rdy[0] !== 1'b1) $display("FAIL aw_ready_held got=%b want=1", in_rdy[0]);
        else passed++;
        @(negedge clk);
        checks++;
        if (out_v[0] !== 1'b0) $display("FAIL aw_single_beat got=%b want=0", out_v[0]);
        else passed++;
        out_r[0] = 1'b0;
    endtask

    task automatic test_atop();
        logic [MAXW-1:0] aw;
        logic [5:0]      want_atop;
        aw = MAXW'({6'h11, 32'h0000_1000, 8'd0, 3'd3, 2'd1, 1'b0, 4'h0, 3'h0, 4'h0, 4'h0, 6'h21, 1'b0});
`ifdef AXI_SLICE_ATOP_EN
        want_atop = 6'h21;
`else
        want_atop = 6'h00;
`endif
        out_r[0] = 1'b1;
        in_v[0]  = 1'b1;
        in_d[0]  = aw;
        @(negedge clk);
        in_v[0] = 1'b0;
        checks++;
        if (m_aw[AW_ATOP_LSB +: ATOP_BITS] !== want_atop)
            $display("FAIL atop_field got=%h want=%h", m_aw[AW_ATOP_LSB +: ATOP_BITS], want_atop);
        else passed++;
        checks++;
        if (m_aw[AW_W-1:AW_QOS_LSB] !== aw[AW_W-1:AW_QOS_LSB])
            $display("FAIL atop_other_fields got=%h want=%h", m_aw[AW_W-1:AW_QOS_LSB], aw[AW_W-1:AW_QOS_LSB]);
        else passed++;
        @(negedge clk);
        out_r[0] = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [MAXW-1:0] b1, b2, b3;
        b1 = MAXW'({64'h1111_1111_1111_1111, 8'hFF, 1'b0, 1'b0});
        b2 = MAXW'({64'h2222_2222_2222_2222, 8'hFF, 1'b1, 1'b0});
        b3 = MAXW'({64'h3333_3333_3333_3333, 8'h0F, 1'b1, 1'b1});
        out_r[1] = 1'b0;
        in_v[1]  = 1'b1;
        in_d[1]  = b1;
        @(negedge clk);
        in_d[1] = b2;
        checks++;
        if (in_rdy[1] !== 1'b1) $display("FAIL bp_ready_beat2 got=%b want=1", in_rdy[1]);
        else passed++;
        @(negedge clk);
        in_d[1] = b3;
        checks++;
        if (in_rdy[1] !== 1'b0) $display("FAIL bp_ready_full got=%b want=0", in_rdy[1]);
        else passed++;
        @(negedge clk);
        checks++;
        if (out_d[1] !== b1 || out_v[1] !== 1'b1) $display("FAIL bp_stall_hold got=%h want=%h", out_d[1], b1);
        else passed++;
        checks++;
        if (in_rdy[1] !== 1'b0) $display("FAIL bp_ready_still_full got=%b want=0", in_rdy[1]);
        else passed++;
        out_r[1] = 1'b1;
        @(negedge clk);
        checks++;
        if (out_d[1] !== b2 || out_v[1] !== 1'b1) $display("FAIL bp_beat2 got=%h want=%h", out_d[1], b2);
        else passed++;
        checks++;
        if (in_rdy[1] !== 1'b1) $display("FAIL bp_ready_reopen got=%b want=1", in_rdy[1]);
        else passed++;
        @(negedge clk);
        in_v[1] = 1'b0;
        checks++;
        if (out_d[1] !== b3 || out_v[1] !== 1'b1) $display("FAIL bp_beat3 got=%h want=%h", out_d[1], b3);
        else passed++;
        @(negedge clk);
        checks++;
        if (out_v[1] !== 1'b0) $display("FAIL bp_empty got=%b want=0", out_v[1]);
        else passed++;
        out_r[1] = 1'b0;
    endtask

    function automatic logic [MAXW-1:0] r_beat(input int k);
        return MAXW'({6'h2A, 32'hCAFE_0000 | 32'(k), 32'(k * 3 + 1), 2'b00, (k == 15), 1'b0});
    endfunction

    task automatic test_streaming();
        out_r[4] = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            if (k < 16) begin
                in_v[4] = 1'b1;
                in_d[4] = r_beat(k);
            end else begin
                in_v[4] = 1'b0;
            end
            if (k > 0) begin
                checks++;
                if (out_v[4] !== 1'b1 || out_d[4] !== r_beat(k - 1))
                    $display("FAIL stream_beat%0d got=%b/%h want=1/%h", k - 1, out_v[4], out_d[4], r_beat(k - 1));
                else passed++;
            end
            checks++;
            if (in_rdy[4] !== 1'b1) $display("FAIL stream_ready%0d got=%b want=1", k, in_rdy[4]);
            else passed++;
            @(negedge clk);
        end
        checks++;
        if (out_v[4] !== 1'b0) $display("FAIL stream_tail got=%b want=0", out_v[4]);
        else passed++;
        out_r[4] = 1'b0;
    endtask

    task automatic test_random();
        int unsigned in_seq  [NCH];
        int unsigned out_seq [NCH];
        logic        hs_in   [NCH];
        logic        hs_out  [NCH];
        logic        stall   [NCH];
        for (int c = 0; c < NCH; c++) begin
            in_seq[c] = 0; out_seq[c] = 0;
            hs_in[c] = 1'b0; hs_out[c] = 1'b0; stall[c] = 1'b0;
            in_v[c] = 1'b0; out_r[c] = 1'b0;
        end
        for (int cyc = 0; cyc < RAND_CYC + DRAIN; cyc++) begin
            @(negedge clk);
            for (int c = 0; c < NCH; c++) begin
                if (hs_in[c])  in_seq[c]++;
                if (hs_out[c]) out_seq[c]++;
                if (out_v[c]) begin
                    checks++;
                    if (out_d[c] !== exp_out(c, pay(c, out_seq[c])))
                        $display("FAIL rand_ch%0d beat%0d cyc%0d got=%h want=%h", c, out_seq[c], cyc,
                                 out_d[c], exp_out(c, pay(c, out_seq[c])));
                    else passed++;
                end else if (stall[c]) begin
                    checks++;
                    $display("FAIL rand_ch%0d valid_dropped cyc%0d got=0 want=1", c, cyc);
                end
                // A pending beat stays on the bus until it is accepted.
                if (!in_v[c] || hs_in[c]) begin
                    in_v[c] = (cyc < RAND_CYC) && ($urandom_range(0, 3) != 0);
                    in_d[c] = pay(c, in_seq[c]);
                end
                out_r[c]  = (cyc >= RAND_CYC) || ($urandom_range(0, 2) != 0);
                hs_in[c]  = in_v[c] & in_rdy[c];
                hs_out[c] = out_v[c] & out_r[c];
                stall[c]  = out_v[c] & ~out_r[c];
            end
        end
        @(negedge clk);
        for (int c = 0; c < NCH; c++) begin
            if (hs_in[c])  in_seq[c]++;
            if (hs_out[c]) out_seq[c]++;
            checks++;
            if (out_seq[c] !== in_seq[c] || in_seq[c] < 100)
                $display("FAIL rand_count_ch%0d got=%0d want=%0d", c, out_seq[c], in_seq[c]);
            else passed++;
        end
        idle_all();
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        idle_all();
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < NCH; c++) begin
                in_v[c] = 1'b1;
                in_d[c] = pay(c, 500 + k);
            end
            @(negedge clk);
        end
        for (int c = 0; c < NCH; c++) begin
            in_v[c] = 1'b0;
            checks++;
            if (in_rdy[c] !== 1'b0 || out_v[c] !== 1'b1)
                $display("FAIL ar_full ch%0d got=%b%b want=01", c, in_rdy[c], out_v[c]);
            else passed++;
        end
        #2 rstn = 1'b0;
        #1;
        for (int c = 0; c < NCH; c++) begin
            checks++;
            if (out_v[c] !== 1'b0) $display("FAIL ar_async_valid ch%0d got=%b want=0", c, out_v[c]);
            else passed++;
            checks++;
            if (in_rdy[c] !== 1'b1) $display("FAIL ar_async_ready ch%0d got=%b want=1", c, in_rdy[c]);
            else passed++;
        end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        for (int c = 0; c < NCH; c++) begin
            checks++;
            if (out_v[c] !== 1'b0 || in_rdy[c] !== 1'b1)
                $display("FAIL ar_release ch%0d got=%b%b want=01", c, out_v[c], in_rdy[c]);
            else passed++;
        end
    endtask

    initial begin
        idle_all();
        test_reset();
        test_single_aw();
        test_atop();
        test_backpressure();
        test_streaming();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
